// File: rtl/vga_game_pkg.sv
// Shared types for the quadrant game: move directions, grid positions,
// scheduler states and the move-target helper.
package vga_game_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef struct packed {
        logic x;
        logic y;
    } quad_t;

    localparam quad_t P1_RESET_QUAD = '{x: 1'b0, y: 1'b0};
    localparam quad_t P2_RESET_QUAD = '{x: 1'b1, y: 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RESOLVE = 2'b01,
        COMMIT  = 2'b10
    } sched_state_t;

    typedef enum logic {
        PRI_P1 = 1'b0,
        PRI_P2 = 1'b1
    } prio_t;

    // A move only ever touches one axis; hitting the grid edge returns pos unchanged.
    function automatic quad_t move_target(input quad_t pos, input dir_t dir);
        quad_t t;
        t = pos;
        case (dir)
            UP:      t.y = 1'b0;
            DOWN:    t.y = 1'b1;
            LEFT:    t.x = 1'b0;
            RIGHT:   t.x = 1'b1;
            default: t = pos;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/player_position_scheduler_if.sv
// Request handshakes, frame pulse and position/collision outputs between the
// input logic (master) and the position scheduler (slave).
interface player_position_scheduler_if;
    import vga_game_pkg::*;

    logic frame_start;
    logic p1_req_valid;
    dir_t p1_req_dir;
    logic p1_req_ready;
    logic p2_req_valid;
    dir_t p2_req_dir;
    logic p2_req_ready;
    logic p1x;
    logic p1y;
    logic p2x;
    logic p2y;
    logic collision;

    modport master (
        output frame_start, p1_req_valid, p1_req_dir, p2_req_valid, p2_req_dir,
        input  p1_req_ready, p2_req_ready, p1x, p1y, p2x, p2y, collision
    );

    modport slave (
        input  frame_start, p1_req_valid, p1_req_dir, p2_req_valid, p2_req_dir,
        output p1_req_ready, p2_req_ready, p1x, p1y, p2x, p2y, collision
    );

endinterface

// File: rtl/player_request_slot.sv
// One player's request slot: valid/ready handshake, single pending move and
// the post-move cooldown counter counted in frames.
module player_request_slot
    import vga_game_pkg::*;
#(
    parameter int unsigned COOLDOWN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic idle_i,
    input  logic frame_tick_i,
    input  logic req_valid_i,
    input  dir_t req_dir_i,
    output logic req_ready_o,
    output logic pending_o,
    output dir_t pending_dir_o,
    input  logic clear_i,
    input  logic load_i
);

    localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic          pending_q, pending_d;
    dir_t          dir_q, dir_d;
    logic [CW-1:0] cooldown_q, cooldown_d;

    assign req_ready_o   = idle_i && !pending_q && (cooldown_q == '0);
    assign pending_o     = pending_q;
    assign pending_dir_o = dir_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        pending_d  = pending_q;
        dir_d      = dir_q;
        cooldown_d = cooldown_q;
        if (clear_i) begin
            pending_d = 1'b0;
        end
        if (req_valid_i && req_ready_o) begin
            pending_d = 1'b1;
            dir_d     = req_dir_i;
        end
        if (load_i) begin
            cooldown_d = CW'(COOLDOWN);
        end else if (frame_tick_i && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 1'b0;
            dir_q      <= UP;
            cooldown_q <= '0;
        end else begin
            pending_q  <= pending_d;
            dir_q      <= dir_d;
            cooldown_q <= cooldown_d;
        end
    end

endmodule

// File: rtl/player_position_scheduler.sv
// Owns both players' quadrant positions; resolves pending moves once per
// vertical blank and commits them two cycles after frame_start.
module player_position_scheduler
    import vga_game_pkg::*;
#(
    parameter int unsigned MOVE_COOLDOWN_FRAMES = 8,
    parameter bit          ALLOW_SHARE          = 1'b0
) (
    input logic                         clk,
    input logic                         reset_n,
    player_position_scheduler_if.slave  bus
);

    sched_state_t state_q, state_d;
    quad_t        p1_q, p1_d, p2_q, p2_d;
    quad_t        res1_q, res1_d, res2_q, res2_d;
    logic         act1_q, act1_d, act2_q, act2_d;
    logic         moved1_q, moved1_d, moved2_q, moved2_d;
    logic         collision_q, collision_d;
    prio_t        prio_q, prio_d, prio_nxt;

    logic  idle, frame_tick;
    logic  p1_pending, p2_pending;
    dir_t  p1_dir, p2_dir;
    quad_t t1, t2;
    logic  mv1, mv2, go1, go2, coll;

    assign idle       = (state_q == IDLE);
    assign frame_tick = idle && bus.frame_start;

    player_request_slot #(.COOLDOWN(MOVE_COOLDOWN_FRAMES)) u_slot_p1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .idle_i       (idle),
        .frame_tick_i (frame_tick),
        .req_valid_i  (bus.p1_req_valid),
        .req_dir_i    (bus.p1_req_dir),
        .req_ready_o  (bus.p1_req_ready),
        .pending_o    (p1_pending),
        .pending_dir_o(p1_dir),
        .clear_i      ((state_q == COMMIT) && act1_q),
        .load_i       ((state_q == COMMIT) && moved1_q)
    );

    player_request_slot #(.COOLDOWN(MOVE_COOLDOWN_FRAMES)) u_slot_p2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .idle_i       (idle),
        .frame_tick_i (frame_tick),
        .req_valid_i  (bus.p2_req_valid),
        .req_dir_i    (bus.p2_req_dir),
        .req_ready_o  (bus.p2_req_ready),
        .pending_o    (p2_pending),
        .pending_dir_o(p2_dir),
        .clear_i      ((state_q == COMMIT) && act2_q),
        .load_i       ((state_q == COMMIT) && moved2_q)
    );

    // Edge-of-grid requests drop out here as non-movers before arbitration.
    assign t1  = move_target(p1_q, p1_dir);
    assign t2  = move_target(p2_q, p2_dir);
    assign mv1 = act1_q && (t1 != p1_q);
    assign mv2 = act2_q && (t2 != p2_q);

    always_comb begin
        go1      = mv1;
        go2      = mv2;
        coll     = 1'b0;
        prio_nxt = prio_q;
        if (ALLOW_SHARE == 1'b0) begin
            if (mv1 && mv2 && (t1 == t2)) begin
                coll = 1'b1;
                if (prio_q == PRI_P1) begin
                    go2      = 1'b0;
                    prio_nxt = PRI_P2;
                end else begin
                    go1      = 1'b0;
                    prio_nxt = PRI_P1;
                end
            end else if (mv1 && mv2 && (t1 == p2_q) && (t2 == p1_q)) begin
                go1  = 1'b0;
                go2  = 1'b0;
                coll = 1'b1;
            end else begin
                if (mv1 && !mv2 && (t1 == p2_q)) begin
                    go1  = 1'b0;
                    coll = 1'b1;
                end
                if (mv2 && !mv1 && (t2 == p1_q)) begin
                    go2  = 1'b0;
                    coll = 1'b1;
                end
            end
        end
    end

    // Pendings are snapshotted at frame_start so a same-cycle acceptance waits for the next frame.
    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        res1_d      = res1_q;
        res2_d      = res2_q;
        act1_d      = act1_q;
        act2_d      = act2_q;
        moved1_d    = moved1_q;
        moved2_d    = moved2_q;
        collision_d = 1'b0;
        prio_d      = prio_q;
        case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    state_d = RESOLVE;
                    act1_d  = p1_pending;
                    act2_d  = p2_pending;
                end
            end
            RESOLVE: begin
                state_d     = COMMIT;
                res1_d      = go1 ? t1 : p1_q;
                res2_d      = go2 ? t2 : p2_q;
                moved1_d    = go1;
                moved2_d    = go2;
                collision_d = coll;
                prio_d      = prio_nxt;
            end
            COMMIT: begin
                state_d = IDLE;
                p1_d    = res1_q;
                p2_d    = res2_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            p1_q        <= P1_RESET_QUAD;
            p2_q        <= P2_RESET_QUAD;
            res1_q      <= P1_RESET_QUAD;
            res2_q      <= P2_RESET_QUAD;
            act1_q      <= 1'b0;
            act2_q      <= 1'b0;
            moved1_q    <= 1'b0;
            moved2_q    <= 1'b0;
            collision_q <= 1'b0;
            prio_q      <= PRI_P1;
        end else begin
            state_q     <= state_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            res1_q      <= res1_d;
            res2_q      <= res2_d;
            act1_q      <= act1_d;
            act2_q      <= act2_d;
            moved1_q    <= moved1_d;
            moved2_q    <= moved2_d;
            collision_q <= collision_d;
            prio_q      <= prio_d;
        end
    end

    assign bus.p1x       = p1_q.x;
    assign bus.p1y       = p1_q.y;
    assign bus.p2x       = p2_q.x;
    assign bus.p2y       = p2_q.y;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_player_position_scheduler.sv
// Scoreboard bench: one scheduler with default parameters and one with
// sharing enabled and no cooldown.
module tb_player_position_scheduler;
    import vga_game_pkg::*;

    typedef struct {
        quad_t p1;
        quad_t p2;
        logic  coll;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    quad_t m1[2];
    quad_t m2[2];

    localparam quad_t Q00 = '{x: 1'b0, y: 1'b0};
    localparam quad_t Q01 = '{x: 1'b0, y: 1'b1};
    localparam quad_t Q10 = '{x: 1'b1, y: 1'b0};
    localparam quad_t Q11 = '{x: 1'b1, y: 1'b1};

    player_position_scheduler_if bd ();
    player_position_scheduler_if bs ();

    player_position_scheduler u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bd)
    );

    player_position_scheduler #(
        .MOVE_COOLDOWN_FRAMES(0),
        .ALLOW_SHARE         (1'b1)
    ) u_dut_sh (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic quad_t pos1(input bit sh);
        return sh ? quad_t'({bs.p1x, bs.p1y}) : quad_t'({bd.p1x, bd.p1y});
    endfunction

    function automatic quad_t pos2(input bit sh);
        return sh ? quad_t'({bs.p2x, bs.p2y}) : quad_t'({bd.p2x, bd.p2y});
    endfunction

    function automatic logic coll_of(input bit sh);
        return sh ? bs.collision : bd.collision;
    endfunction

    function automatic logic ready_of(input bit sh, input int pl);
        if (sh) return (pl == 1) ? bs.p1_req_ready : bs.p2_req_ready;
        return (pl == 1) ? bd.p1_req_ready : bd.p2_req_ready;
    endfunction

    task automatic set_fs(input bit sh, input logic v);
        if (sh) bs.frame_start = v;
        else    bd.frame_start = v;
    endtask

    task automatic set_req(input bit sh, input int pl, input logic v, input dir_t d);
        if (sh) begin
            if (pl == 1) begin bs.p1_req_valid = v; bs.p1_req_dir = d; end
            else         begin bs.p2_req_valid = v; bs.p2_req_dir = d; end
        end else begin
            if (pl == 1) begin bd.p1_req_valid = v; bd.p1_req_dir = d; end
            else         begin bd.p2_req_valid = v; bd.p2_req_dir = d; end
        end
    endtask

    // One-cycle request; ready is checked just before the accepting edge.
    task automatic request(input bit sh, input int pl, input dir_t d, input logic exp_rdy,
                           input string tag);
        check({tag, ".rdy"}, ready_of(sh, pl), exp_rdy);
        set_req(sh, pl, 1'b1, d);
        @(negedge clk);
        set_req(sh, pl, 1'b0, d);
    endtask

    // frame_start high for 'hold' edges starting at edge T; positions land at T+2.
    task automatic frame(input bit sh, input quad_t e1, input quad_t e2, input logic ecoll,
                         input int hold, input string tag);
        exp_t e;
        exp_q.push_back('{p1: e1, p2: e2, coll: ecoll});
        set_fs(sh, 1'b1);
        @(negedge clk);
        set_fs(sh, hold > 1);
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".coll"}, coll_of(sh), e.coll);
        check({tag, ".p1_old"}, pos1(sh), m1[sh]);
        check({tag, ".p2_old"}, pos2(sh), m2[sh]);
        set_fs(sh, hold > 2);
        @(negedge clk);
        set_fs(sh, 1'b0);
        check({tag, ".p1"}, pos1(sh), e.p1);
        check({tag, ".p2"}, pos2(sh), e.p2);
        check({tag, ".coll_end"}, coll_of(sh), 1'b0);
        m1[sh] = e.p1;
        m2[sh] = e.p2;
    endtask

    task automatic idle_frames(input bit sh, input int n, input int hold, input string tag);
        for (int i = 0; i < n; i++) begin
            frame(sh, m1[sh], m2[sh], 1'b0, hold, tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bd.frame_start = 1'b0; bs.frame_start = 1'b0;
        set_req(1'b0, 1, 1'b0, UP); set_req(1'b0, 2, 1'b0, UP);
        set_req(1'b1, 1, 1'b0, UP); set_req(1'b1, 2, 1'b0, UP);
        for (int s = 0; s < 2; s++) begin
            m1[s] = P1_RESET_QUAD;
            m2[s] = P2_RESET_QUAD;
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state and an empty frame.
        check("rst.p1", pos1(0), Q00);
        check("rst.p2", pos2(0), Q11);
        check("rst.rdy1", ready_of(0, 1), 1'b1);
        check("rst.rdy2", ready_of(0, 2), 1'b1);
        check("rst.coll", coll_of(0), 1'b0);
        frame(0, Q00, Q11, 1'b0, 1, "empty");

        // Single move, then eight frames of cooldown with a held request ignored.
        request(0, 1, RIGHT, 1'b1, "mv");
        check("mv.pend_rdy", ready_of(0, 1), 1'b0);
        frame(0, Q10, Q11, 1'b0, 1, "mv");
        check("cd.rdy_post", ready_of(0, 1), 1'b0);
        check("cd.rdy2", ready_of(0, 2), 1'b1);
        set_req(0, 1, 1'b1, DOWN);
        frame(0, Q10, Q11, 1'b0, 1, "cd.held");
        set_req(0, 1, 1'b0, DOWN);
        idle_frames(0, 6, 1, "cd");
        check("cd.rdy7", ready_of(0, 1), 1'b0);
        idle_frames(0, 1, 1, "cd8");
        check("cd.rdy8", ready_of(0, 1), 1'b1);

        // Contested target, P1 has priority.
        request(0, 1, LEFT, 1'b1, "setup1");
        frame(0, Q00, Q11, 1'b0, 1, "setup1");
        idle_frames(0, 8, 1, "setup1.cd");
        request(0, 1, DOWN, 1'b1, "con1.p1");
        request(0, 2, LEFT, 1'b1, "con1.p2");
        frame(0, Q01, Q11, 1'b1, 1, "con1");
        check("con1.rdy1", ready_of(0, 1), 1'b0);
        check("con1.rdy2", ready_of(0, 2), 1'b1);

        // Symmetric contest, P2 now has priority.
        request(0, 2, UP, 1'b1, "setup2");
        frame(0, Q01, Q10, 1'b0, 1, "setup2");
        idle_frames(0, 8, 1, "setup2.cd");
        request(0, 1, RIGHT, 1'b1, "con2.p1");
        request(0, 2, DOWN, 1'b1, "con2.p2");
        frame(0, Q01, Q11, 1'b1, 1, "con2");
        check("con2.rdy1", ready_of(0, 1), 1'b1);
        check("con2.rdy2", ready_of(0, 2), 1'b0);

        // Swap, stationary block and vacate from p1=(0,0), p2=(1,0).
        request(0, 1, UP, 1'b1, "setup3");
        frame(0, Q00, Q11, 1'b0, 1, "setup3");
        idle_frames(0, 8, 1, "setup3.cd");
        request(0, 2, UP, 1'b1, "setup4");
        frame(0, Q00, Q10, 1'b0, 1, "setup4");
        idle_frames(0, 8, 1, "setup4.cd");
        request(0, 1, RIGHT, 1'b1, "swap.p1");
        request(0, 2, LEFT, 1'b1, "swap.p2");
        frame(0, Q00, Q10, 1'b1, 1, "swap");
        check("swap.rdy1", ready_of(0, 1), 1'b1);
        check("swap.rdy2", ready_of(0, 2), 1'b1);
        request(0, 1, RIGHT, 1'b1, "block");
        frame(0, Q00, Q10, 1'b1, 1, "block");
        check("block.rdy1", ready_of(0, 1), 1'b1);
        request(0, 1, RIGHT, 1'b1, "vac.p1");
        request(0, 2, DOWN, 1'b1, "vac.p2");
        frame(0, Q10, Q11, 1'b0, 1, "vac");
        idle_frames(0, 8, 1, "vac.cd");

        // Edge no-op, then frame_start held through RESOLVE/COMMIT must not count.
        request(0, 1, UP, 1'b1, "noop");
        frame(0, Q10, Q11, 1'b0, 1, "noop");
        check("noop.rdy1", ready_of(0, 1), 1'b1);
        request(0, 2, LEFT, 1'b1, "mv2");
        frame(0, Q10, Q01, 1'b0, 1, "mv2");
        idle_frames(0, 7, 3, "hold3");
        check("hold3.rdy2", ready_of(0, 2), 1'b0);
        idle_frames(0, 1, 1, "hold3.last");
        check("hold3.rdy2_end", ready_of(0, 2), 1'b1);

        // Request accepted with frame_start waits for the following frame.
        set_req(0, 1, 1'b1, DOWN);
        frame(0, Q10, Q01, 1'b0, 1, "late");
        set_req(0, 1, 1'b0, DOWN);
        frame(0, Q11, Q01, 1'b0, 1, "late.next");

        // Reset during RESOLVE discards the pending move.
        request(0, 2, UP, 1'b1, "abort");
        bd.frame_start = 1'b1;
        @(negedge clk);
        bd.frame_start = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort.p1", pos1(0), Q00);
        check("abort.p2", pos2(0), Q11);
        check("abort.coll", coll_of(0), 1'b0);
        check("abort.rdy1", ready_of(0, 1), 1'b1);
        check("abort.rdy2", ready_of(0, 2), 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        m1[0] = P1_RESET_QUAD;
        m2[0] = P2_RESET_QUAD;
        @(negedge clk);
        frame(0, Q00, Q11, 1'b0, 1, "abort.after");

        // Sharing allowed: both land on (0,1) with no collision and no cooldown.
        request(1, 1, DOWN, 1'b1, "share.p1");
        request(1, 2, LEFT, 1'b1, "share.p2");
        frame(1, Q01, Q01, 1'b0, 1, "share");
        check("share.rdy1", ready_of(1, 1), 1'b1);
        check("share.rdy2", ready_of(1, 2), 1'b1);

        check("sb.empty", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
